// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache (client 0) and D-cache (client 1) for one memory port.
// An owner FIFO routes in-order read responses back to the cache that issued each read.
module mem_arbiter #(
    parameter int unsigned MEM_DATA_BITS = 128,
    parameter int unsigned MEM_ADDR_BITS = 28,
    parameter int unsigned RESP_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       c0_req_valid,
    output logic                       c0_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   c0_req_addr,
    input  logic                       c0_req_rw,
    input  logic                       c0_req_data_valid,
    output logic                       c0_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   c0_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] c0_req_data_mask,
    output logic                       c0_resp_valid,

    input  logic                       c1_req_valid,
    output logic                       c1_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   c1_req_addr,
    input  logic                       c1_req_rw,
    input  logic                       c1_req_data_valid,
    output logic                       c1_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   c1_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] c1_req_data_mask,
    output logic                       c1_resp_valid,

    output logic [MEM_DATA_BITS-1:0]   resp_data,

    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
    output logic                       resp_err
);

    localparam int unsigned PTR_BITS = $clog2(RESP_DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    typedef enum logic [1:0] {StIdle, StReq, StWdata} state_e;

    state_e              state_q;
    logic                grant_q;
    logic                rr_last_q;
    logic                data_done_q;
    logic                resp_err_q;
    logic                owner_q [RESP_DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [CNT_BITS-1:0] count_q;

    logic fifo_full, fifo_empty, elig0, elig1;
    logic g_rw, g_data_valid, g_req_ready, g_data_ready;
    logic addr_hs, data_hs, push, pop, head;

    assign fifo_full  = (count_q == CNT_BITS'(RESP_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign elig0      = c0_req_valid && (c0_req_rw || !fifo_full);
    assign elig1      = c1_req_valid && (c1_req_rw || !fifo_full);

    assign g_rw              = grant_q ? c1_req_rw : c0_req_rw;
    assign g_data_valid      = grant_q ? c1_req_data_valid : c0_req_data_valid;
    assign mem_req_addr      = grant_q ? c1_req_addr : c0_req_addr;
    assign mem_req_rw        = g_rw;
    assign mem_req_data_bits = grant_q ? c1_req_data_bits : c0_req_data_bits;
    assign mem_req_data_mask = grant_q ? c1_req_data_mask : c0_req_data_mask;

    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        g_req_ready        = 1'b0;
        g_data_ready       = 1'b0;
        if (!reset) begin
            case (state_q)
                StReq: begin
                    mem_req_valid      = 1'b1;
                    g_req_ready        = mem_req_ready;
                    // A beat already accepted ahead of the address must not be sent twice.
                    mem_req_data_valid = g_data_valid && g_rw && !data_done_q;
                    g_data_ready       = mem_req_data_ready && g_rw && !data_done_q;
                end
                StWdata: begin
                    mem_req_data_valid = g_data_valid;
                    g_data_ready       = mem_req_data_ready;
                end
                default: ;
            endcase
        end
    end

    assign c0_req_ready      = g_req_ready && !grant_q;
    assign c1_req_ready      = g_req_ready && grant_q;
    assign c0_req_data_ready = g_data_ready && !grant_q;
    assign c1_req_data_ready = g_data_ready && grant_q;

    assign addr_hs = mem_req_valid && mem_req_ready;
    assign data_hs = mem_req_data_valid && mem_req_data_ready;
    assign push    = addr_hs && !g_rw;
    assign pop     = !reset && mem_resp_valid && !fifo_empty;
    assign head    = owner_q[rd_ptr_q];

    assign c0_resp_valid = pop && !head;
    assign c1_resp_valid = pop && head;
    assign resp_data     = mem_resp_data;
    assign resp_err      = resp_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            data_done_q <= 1'b0;
            resp_err_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (elig0 && elig1) begin
                        grant_q <= ~rr_last_q;
                        state_q <= StReq;
                    end else if (elig0) begin
                        grant_q <= 1'b0;
                        state_q <= StReq;
                    end else if (elig1) begin
                        grant_q <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (addr_hs) begin
                        if (!g_rw || data_hs || data_done_q) begin
                            rr_last_q   <= grant_q;
                            data_done_q <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            state_q <= StWdata;
                        end
                    end else if (data_hs) begin
                        data_done_q <= 1'b1;
                    end
                end
                StWdata: begin
                    if (data_hs) begin
                        rr_last_q <= grant_q;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (push) begin
                owner_q[wr_ptr_q] <= grant_q;
                wr_ptr_q          <= wr_ptr_q + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_BITS'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_BITS'(1);
            end

            if (mem_resp_valid && fifo_empty) begin
                resp_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, write-data timing, owner FIFO routing,
// full-FIFO stalls, spurious responses and reset mid-transaction.
module tb_mem_arbiter;

    localparam int MDB = 128;
    localparam int MAB = 28;
    localparam int MKB = MDB / 8;

    logic           clk, reset;
    logic           c0_req_valid, c0_req_ready, c0_req_rw, c0_req_data_valid, c0_req_data_ready;
    logic [MAB-1:0] c0_req_addr;
    logic [MDB-1:0] c0_req_data_bits;
    logic [MKB-1:0] c0_req_data_mask;
    logic           c0_resp_valid;
    logic           c1_req_valid, c1_req_ready, c1_req_rw, c1_req_data_valid, c1_req_data_ready;
    logic [MAB-1:0] c1_req_addr;
    logic [MDB-1:0] c1_req_data_bits;
    logic [MKB-1:0] c1_req_data_mask;
    logic           c1_resp_valid;
    logic [MDB-1:0] resp_data;
    logic           mem_req_valid, mem_req_ready, mem_req_rw;
    logic [MAB-1:0] mem_req_addr;
    logic           mem_req_data_valid, mem_req_data_ready;
    logic [MDB-1:0] mem_req_data_bits;
    logic [MKB-1:0] mem_req_data_mask;
    logic           mem_resp_valid;
    logic [MDB-1:0] mem_resp_data;
    logic           resp_err;

    int total;
    int bad;
    int beats;
    int beats_start;

    mem_arbiter #(.MEM_DATA_BITS(MDB), .MEM_ADDR_BITS(MAB), .RESP_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_addr(c0_req_addr),
        .c0_req_rw(c0_req_rw), .c0_req_data_valid(c0_req_data_valid),
        .c0_req_data_ready(c0_req_data_ready), .c0_req_data_bits(c0_req_data_bits),
        .c0_req_data_mask(c0_req_data_mask), .c0_resp_valid(c0_resp_valid),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_addr(c1_req_addr),
        .c1_req_rw(c1_req_rw), .c1_req_data_valid(c1_req_data_valid),
        .c1_req_data_ready(c1_req_data_ready), .c1_req_data_bits(c1_req_data_bits),
        .c1_req_data_mask(c1_req_data_mask), .c1_resp_valid(c1_resp_valid),
        .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .resp_err(resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_req_data_valid && mem_req_data_ready) beats <= beats + 1;
    end

    task automatic chk(input string tag, input logic [MDB-1:0] got, input logic [MDB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        c0_req_valid = 0; c0_req_addr = '0; c0_req_rw = 0; c0_req_data_valid = 0;
        c0_req_data_bits = '0; c0_req_data_mask = '0;
        c1_req_valid = 0; c1_req_addr = '0; c1_req_rw = 0; c1_req_data_valid = 0;
        c1_req_data_bits = '0; c1_req_data_mask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        step();
        step();
        reset = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset: every valid/ready output held low even with stimulus active.
        clear_inputs();
        reset = 1;
        c0_req_valid = 1; mem_req_ready = 1; mem_req_data_ready = 1; mem_resp_valid = 1;
        step();
        step();
        settle();
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_c0_req_ready", c0_req_ready, 0);
        chk("rst_c0_resp_valid", c0_resp_valid, 0);
        chk("rst_c1_resp_valid", c1_resp_valid, 0);
        reset = 0;
        clear_inputs();
        settle();
        chk("rst_resp_err", resp_err, 0);
        chk("rst_idle_valid", mem_req_valid, 0);

        // Single read from c0.
        do_reset();
        c0_req_valid = 1; c0_req_rw = 0; c0_req_addr = 28'h10; mem_req_ready = 1;
        settle();
        chk("rd_idle_valid", mem_req_valid, 0);
        chk("rd_idle_ready", c0_req_ready, 0);
        step();
        chk("rd_req_valid", mem_req_valid, 1);
        chk("rd_req_addr", mem_req_addr, 28'h10);
        chk("rd_req_rw", mem_req_rw, 0);
        chk("rd_c0_ready", c0_req_ready, 1);
        chk("rd_c1_ready", c1_req_ready, 0);
        step();
        c0_req_valid = 0;
        mem_resp_valid = 1; mem_resp_data = {16{8'hAB}};
        settle();
        chk("rd_back_idle", mem_req_valid, 0);
        chk("rd_c0_resp", c0_resp_valid, 1);
        chk("rd_c1_resp", c1_resp_valid, 0);
        chk("rd_resp_data", resp_data, {16{8'hAB}});
        step();
        mem_resp_valid = 0;
        settle();
        chk("rd_no_err", resp_err, 0);

        // Contention: both clients read continuously, grants alternate from c0.
        do_reset();
        c0_req_valid = 1; c1_req_valid = 1; c0_req_addr = 28'h100; c1_req_addr = 28'h200;
        mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_c0_ready", c0_req_ready, (i % 2) == 0);
            chk("rr_c1_ready", c1_req_ready, (i % 2) == 1);
            chk("rr_addr", mem_req_addr, (i % 2) == 0 ? 28'h100 : 28'h200);
            step();
        end
        c0_req_valid = 0; c1_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1;
            settle();
            chk("rr_resp_c0", c0_resp_valid, (i % 2) == 0);
            chk("rr_resp_c1", c1_resp_valid, (i % 2) == 1);
            step();
        end
        mem_resp_valid = 0;

        // c1 write, data arrives three cycles after the address handshake.
        do_reset();
        c1_req_valid = 1; c1_req_rw = 1; c1_req_addr = 28'h3;
        c1_req_data_bits = {4{32'hDEAD_BEEF}}; c1_req_data_mask = 16'h00F0;
        mem_req_ready = 1; mem_req_data_ready = 1;
        step();
        c0_req_valid = 1; c0_req_addr = 28'h44;
        settle();
        chk("wl_c1_ready", c1_req_ready, 1);
        chk("wl_c0_ready", c0_req_ready, 0);
        chk("wl_no_data", mem_req_data_valid, 0);
        step();
        c1_req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("wl_wdata_valid", mem_req_valid, 0);
            chk("wl_wdata_dv", mem_req_data_valid, 0);
            chk("wl_wdata_c0", c0_req_ready, 0);
            step();
        end
        c1_req_data_valid = 1;
        settle();
        chk("wl_dv", mem_req_data_valid, 1);
        chk("wl_dready", c1_req_data_ready, 1);
        chk("wl_bits", mem_req_data_bits, {4{32'hDEAD_BEEF}});
        chk("wl_mask", mem_req_data_mask, 16'h00F0);
        chk("wl_c0_hold", c0_req_ready, 0);
        step();
        c1_req_data_valid = 0;
        settle();
        chk("wl_idle", mem_req_valid, 0);
        step();
        chk("wl_c0_granted", c0_req_ready, 1);
        step();
        c0_req_valid = 0;

        // c0 write, data accepted before the address.
        do_reset();
        c0_req_valid = 1; c0_req_rw = 1; c0_req_addr = 28'h5; c0_req_data_valid = 1;
        c0_req_data_bits = {8{16'h1234}}; c0_req_data_mask = 16'hFFFF;
        mem_req_data_ready = 1;
        beats_start = beats;
        step();
        chk("wf_dv", mem_req_data_valid, 1);
        chk("wf_dready", c0_req_data_ready, 1);
        chk("wf_no_addr", c0_req_ready, 0);
        step();
        c0_req_data_valid = 0;
        settle();
        chk("wf_done_dv", mem_req_data_valid, 0);
        chk("wf_still_req", mem_req_valid, 1);
        mem_req_ready = 1;
        settle();
        chk("wf_addr_ready", c0_req_ready, 1);
        step();
        c0_req_valid = 0;
        settle();
        chk("wf_idle", mem_req_valid, 0);
        step();
        chk("wf_stays_idle", mem_req_valid, 0);
        chk("wf_one_beat", beats - beats_start, 1);

        // Full owner FIFO stalls reads but still grants writes.
        do_reset();
        c0_req_valid = 1; c0_req_addr = 28'h20; mem_req_ready = 1; mem_req_data_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ff_fill", c0_req_ready, 1);
            step();
        end
        c1_req_valid = 1; c1_req_rw = 1; c1_req_addr = 28'h7; c1_req_data_valid = 1;
        c1_req_data_bits = {2{64'h0F0F_0F0F_0F0F_0F0F}};
        step();
        chk("ff_wr_granted", c1_req_ready, 1);
        chk("ff_rd_blocked", c0_req_ready, 0);
        chk("ff_wr_rw", mem_req_rw, 1);
        chk("ff_wr_dv", mem_req_data_valid, 1);
        step();
        c1_req_valid = 0; c1_req_data_valid = 0;
        step();
        chk("ff_stall", mem_req_valid, 0);
        mem_resp_valid = 1;
        settle();
        chk("ff_pop_c0", c0_resp_valid, 1);
        step();
        mem_resp_valid = 0;
        settle();
        chk("ff_pop_idle", mem_req_valid, 0);
        step();
        mem_resp_valid = 1;
        settle();
        chk("ff_regrant", c0_req_ready, 1);
        chk("ff_pushpop_resp", c0_resp_valid, 1);
        step();
        mem_resp_valid = 0;
        step();
        chk("ff_refill", c0_req_ready, 1);
        step();
        step();
        chk("ff_stall2", mem_req_valid, 0);
        c0_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1;
            settle();
            chk("ff_drain", c0_resp_valid, 1);
            step();
        end
        settle();
        chk("sp_c0", c0_resp_valid, 0);
        chk("sp_c1", c1_resp_valid, 0);
        chk("sp_err_pre", resp_err, 0);
        step();
        mem_resp_valid = 0;
        settle();
        chk("sp_err_set", resp_err, 1);
        step();
        chk("sp_err_sticky", resp_err, 1);

        // Reset while waiting for write data.
        do_reset();
        settle();
        chk("wr_rst_err_clear", resp_err, 0);
        c1_req_valid = 1; c1_req_rw = 1; c1_req_addr = 28'h9;
        mem_req_ready = 1; mem_req_data_ready = 1;
        step();
        step();
        c1_req_valid = 0;
        settle();
        chk("wr_rst_wdata", mem_req_valid, 0);
        chk("wr_rst_dready", c1_req_data_ready, 1);
        reset = 1;
        settle();
        chk("wr_rst_gated", c1_req_data_ready, 0);
        step();
        reset = 0;
        settle();
        chk("wr_rst_idle_dr", c1_req_data_ready, 0);
        chk("wr_rst_idle_v", mem_req_valid, 0);
        mem_resp_valid = 1;
        settle();
        chk("wr_rst_empty_c0", c0_resp_valid, 0);
        chk("wr_rst_empty_c1", c1_resp_valid, 0);
        step();
        mem_resp_valid = 0;
        settle();
        chk("wr_rst_err", resp_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
